// File: rtl/fcmp_pipe.sv
// Two-stage IEEE-754 compare / min-max unit (FEQ, FLT, FLE, FMIN, FMAX) with tag passthrough and RISC-V NV flag.
// Define FCMP_FCLASS_EN to build op 5 as FCLASS on in_a; otherwise op 5 is reserved.
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_nv
);
  localparam int WIDTH = 1 + EXP_W + MAN_W;
  localparam int MAG_W = EXP_W + MAN_W;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid
  // and payload hold until then. A stage loads when the stage after it is empty
  // or handing its content on in the same cycle, so there are no bubbles.
  logic s1_v, s2_v, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, s2_data;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             s2_nv;
  // class bits per operand: {sign, qnan, snan, zero}
  logic [3:0]       s1_a_cls, s1_b_cls, in_a_cls, in_b_cls;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign out_nv    = s2_nv;

  function automatic logic [3:0] decode(input logic [WIDTH-1:0] x);
    logic nan;
    nan = (&x[MAG_W-1:MAN_W]) && (|x[MAN_W-1:0]);
    decode = {x[WIDTH-1], nan && x[MAN_W-1], nan && !x[MAN_W-1], ~|x[MAG_W-1:0]};
  endfunction

  assign in_a_cls = decode(in_a);
  assign in_b_cls = decode(in_b);

  // S2 result logic, driven from the S1 registers
  logic a_nan, b_nan, any_nan, any_snan, both_zero, lt_tot, lt, eq;
  logic [WIDTH-1:0] res_data;
  logic             res_nv;
  logic [WIDTH-1:0] canon_nan;

  assign canon_nan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FCMP_FCLASS_EN
  logic [9:0] cls;
  logic       exp_max, exp_zero, frac_zero;
  always_comb begin
    exp_max   = &s1_a[MAG_W-1:MAN_W];
    exp_zero  = ~|s1_a[MAG_W-1:MAN_W];
    frac_zero = ~|s1_a[MAN_W-1:0];
    cls       = '0;
    if (s1_a_cls[1])                 cls[8] = 1'b1;
    else if (s1_a_cls[2])            cls[9] = 1'b1;
    else if (exp_max)                cls[s1_a_cls[3] ? 0 : 7] = 1'b1;
    else if (exp_zero && frac_zero)  cls[s1_a_cls[3] ? 3 : 4] = 1'b1;
    else if (exp_zero)               cls[s1_a_cls[3] ? 2 : 5] = 1'b1;
    else                             cls[s1_a_cls[3] ? 1 : 6] = 1'b1;
  end
`endif

  always_comb begin
    res_data  = '0;
    res_nv    = 1'b0;
    a_nan     = s1_a_cls[2] || s1_a_cls[1];
    b_nan     = s1_b_cls[2] || s1_b_cls[1];
    any_nan   = a_nan || b_nan;
    any_snan  = s1_a_cls[1] || s1_b_cls[1];
    both_zero = s1_a_cls[0] && s1_b_cls[0];
    // total order with -0 < +0; FLT/FLE mask the zero pair back to equal
    if (s1_a_cls[3] != s1_b_cls[3]) lt_tot = s1_a_cls[3];
    else if (s1_a_cls[3])           lt_tot = s1_a[MAG_W-1:0] > s1_b[MAG_W-1:0];
    else                            lt_tot = s1_a[MAG_W-1:0] < s1_b[MAG_W-1:0];
    lt = lt_tot && !both_zero;
    eq = (s1_a == s1_b) || both_zero;
    case (s1_op)
      3'd0: begin res_data[0] = !any_nan && eq;         res_nv = any_snan; end
      3'd1: begin res_data[0] = !any_nan && lt;         res_nv = any_nan;  end
      3'd2: begin res_data[0] = !any_nan && (lt || eq); res_nv = any_nan;  end
      3'd3, 3'd4: begin
        res_nv = any_snan;
        if (a_nan && b_nan) res_data = canon_nan;
        else if (a_nan)     res_data = s1_b;
        else if (b_nan)     res_data = s1_a;
        else if (s1_op == 3'd3) res_data = lt_tot ? s1_a : s1_b;
        else                    res_data = lt_tot ? s1_b : s1_a;
      end
`ifdef FCMP_FCLASS_EN
      3'd5: res_data[9:0] = cls;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_a_cls <= '0;
      s1_b_cls <= '0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_nv    <= 1'b0;
    end else begin
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        if (in_ready) s1_v <= in_valid;
        if (s2_adv)   s2_v <= s1_v;
      end
      if (in_ready && in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_op    <= in_op;
        s1_tag   <= in_tag;
        s1_a_cls <= in_a_cls;
        s1_b_cls <= in_b_cls;
      end
      if (s2_adv && s1_v) begin
        s2_data <= res_data;
        s2_tag  <= s1_tag;
        s2_nv   <= res_nv;
      end
    end
  end
endmodule

// File: tb/tb_fcmp_pipe.sv
// Randomised bench for fcmp_pipe (binary32): reference model on signed ordering keys, tag-ordered scoreboard.
module tb_fcmp_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_nv;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_data;
  logic [TW-1:0] in_tag, out_tag;

  fcmp_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_nv(out_nv)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit last_acc;
  int stall_seen;

  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] tag_q[$];
  logic          nv_q[$];
  int            cyc_q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // reference model: non-NaN values ordered by a signed integer key (both zeros map to 0)
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic nv);
    logic an, bn, asn, bsn;
    longint ka, kb;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ka  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    d   = 0;
    nv  = 0;
    case (op)
      0: begin d = {31'b0, !(an || bn) && ka == kb}; nv = asn || bsn; end
      1: begin d = {31'b0, !(an || bn) && ka <  kb}; nv = an || bn; end
      2: begin d = {31'b0, !(an || bn) && ka <= kb}; nv = an || bn; end
      3, 4: begin
        nv = asn || bsn;
        if (an && bn)  d = 32'h7FC00000;
        else if (an)   d = b;
        else if (bn)   d = a;
        else if (ka != kb) d = ((ka < kb) == (op == 3)) ? a : b;
        else if (op == 3)  d = a[31] ? a : b;
        else               d = a[31] ? b : a;
      end
      5: begin
`ifdef FCMP_FCLASS_EN
        if (asn)                                d = 32'h100;
        else if (an)                            d = 32'h200;
        else if (a[30:23] == 8'hFF)             d = a[31] ? 32'h001 : 32'h080;
        else if (a[30:0] == 0)                  d = a[31] ? 32'h008 : 32'h010;
        else if (a[30:23] == 0)                 d = a[31] ? 32'h004 : 32'h020;
        else                                    d = a[31] ? 32'h002 : 32'h040;
`endif
      end
      default: ;
    endcase
  endfunction

  // one cycle: inputs already driven after negedge; sample, score, advance to next negedge
  task automatic step();
    logic [31:0] d;
    logic        nv;
    bit          exp_ov;
    #1;
    exp_ov = 0;
    if (exp_q.size() > 0) exp_ov = (cyc - cyc_q[0]) >= 2;
    check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
    check("out_valid", out_valid, exp_ov);
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) begin
        check("out_data", out_data, exp_q.pop_front());
        check("out_tag", out_tag, tag_q.pop_front());
        check("out_nv", out_nv, nv_q.pop_front());
        void'(cyc_q.pop_front());
      end else begin
        check("spurious_out", 1, 0);
      end
    end
    if (flush) begin
      exp_q.delete(); tag_q.delete(); nv_q.delete(); cyc_q.delete();
    end
    if (!in_ready && in_valid) stall_seen++;
    last_acc = in_valid && in_ready && !flush;
    if (last_acc) begin
      ref_op(in_op, in_a, in_b, d, nv);
      exp_q.push_back(d); tag_q.push_back(in_tag); nv_q.push_back(nv); cyc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
    int n;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    in_valid = 0; out_ready = 1; flush = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [8];
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'h00000001};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return specials[$urandom_range(0, 7)];
      4, 5:       return {$urandom_range(0, 1) == 1, 8'h7F, 23'($urandom_range(0, 7))};
      default:    return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [31:0] sa [8];
    int sent, k;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_nv", out_nv, 0);
    rst = 0;

    // directed cases
    send(3'd2, 32'h3F800000, 32'h40000000, 5'd3);
    send(3'd1, 32'h7FC00000, 32'h3F800000, 5'd4);
    send(3'd0, 32'h7FC00000, 32'h3F800000, 5'd5);
    send(3'd3, 32'h80000000, 32'h00000000, 5'd6);
    send(3'd4, 32'h7F800001, 32'h7F800001, 5'd7);
    send(3'd4, 32'h80000000, 32'h00000000, 5'd8);
    send(3'd0, 32'h80000000, 32'h00000000, 5'd9);
    send(3'd6, 32'h3F800000, 32'h3F800000, 5'd10);
    send(3'd5, 32'hFF800000, 32'h0, 5'd11);
    send(3'd5, 32'h00000001, 32'h0, 5'd12);
    drain();

    // back-to-back stream with out_ready low on cycles 3..5
    for (int i = 0; i < 8; i++) sa[i] = rand_operand();
    sent = 0; stall_seen = 0; k = 0;
    while ((sent < 8 || exp_q.size() > 0) && k < 40) begin
      in_valid = sent < 8;
      in_op = 3'(sent % 5); in_a = sa[sent % 8]; in_b = sa[(sent + 3) % 8]; in_tag = 5'(20 + sent);
      out_ready = !(k >= 3 && k <= 5);
      step();
      if (last_acc) sent++;
      k++;
    end
    in_valid = 0; out_ready = 1;
    check("stream_sent", sent, 8);
    check("stream_stalled", stall_seen > 0, 1);
    drain();

    // flush with two ops in flight, plus a request presented alongside the flush
    send(3'd1, 32'h3F800000, 32'h40000000, 5'd1);
    send(3'd2, 32'h40000000, 32'h3F800000, 5'd2);
    out_ready = 0; flush = 1; in_valid = 1; in_tag = 5'd30;
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) step();
    flush = 1; in_valid = 1; in_tag = 5'd31;
    step();
    flush = 0; in_valid = 0;
    repeat (4) step();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      a = rand_operand();
      case ($urandom_range(0, 7))
        0, 1:    b = a;
        2:       b = a ^ 32'h80000000;
        default: b = rand_operand();
      endcase
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 39) == 0;
      in_op     = 3'($urandom_range(0, 7));
      in_a = a; in_b = b; in_tag = 5'($urandom);
      step();
    end
    flush = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
